// File: rtl/freq_counter_pkg.sv
// Shared state encoding, BCD digit width and 7-segment decode table for the frequency counter.
package freq_counter_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  // Bit 0 drives segment a, bit 6 segment g; codes 10-15 stay dark.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] seg_decode(input logic [BCD_W-1:0] d);
    return SEG_TABLE[d];
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// Saturating multi-digit BCD event counter with synchronous clear / load-one.
// Count visible the cycle after inc; sticks at all nines and raises ovf until the next clear.
module bcd_counter
  import freq_counter_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      load_one,
  input  logic                      inc,
  output logic [DIGITS*BCD_W-1:0]   count,
  output logic                      ovf
);

  localparam int                CNT_W = DIGITS * BCD_W;
  localparam logic [BCD_W-1:0]  NINE  = BCD_W'(9);

  logic [CNT_W-1:0] count_inc;
  logic             all_nines;
  logic             carry;

  // Ripple the decimal carry through every digit within one cycle.
  always_comb begin
    carry     = 1'b1;
    all_nines = 1'b1;
    count_inc = count;
    for (int d = 0; d < DIGITS; d++) begin
      if (count[d*BCD_W +: BCD_W] != NINE) all_nines = 1'b0;
      if (carry) begin
        if (count[d*BCD_W +: BCD_W] >= NINE) begin
          count_inc[d*BCD_W +: BCD_W] = '0;
        end else begin
          count_inc[d*BCD_W +: BCD_W] = count[d*BCD_W +: BCD_W] + BCD_W'(1);
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= load_one ? CNT_W'(1) : '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      if (all_nines) ovf   <= 1'b1;
      else           count <= count_inc;
    end
  end

endmodule

// File: rtl/freq_counter_mc.sv
// Multi-channel gated frequency counter with BCD results shown on a multiplexed 7-segment display.
// Results and result_valid update the cycle after LATCH; segments lag digit_sel/ch_sel by one cycle.
module freq_counter_mc
  import freq_counter_pkg::*;
#(
  parameter int  NUM_CH    = 2,
  parameter int  PERIOD_W  = 12,
  parameter int  DIGITS    = 2,
  parameter int  REFRESH_W = 4,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   signal_in,
  input  logic [PERIOD_W-1:0] period_in,
  input  logic                load_period,
  input  logic [CH_W-1:0]     ch_sel,
  output logic [6:0]          segments,
  output logic [DIGITS-1:0]   digit_sel,
  output logic [NUM_CH-1:0]   overflow,
  output logic [1:0]          dbg_state,
  output logic                result_valid
);

  localparam int CNT_W = DIGITS * BCD_W;

  state_t                      state;
  logic [PERIOD_W-1:0]         period_act, period_shadow, period_next, gate;
  logic [NUM_CH-1:0]           sync1, sync2, sync3, edges, cnt_ovf;
  logic [NUM_CH-1:0][CNT_W-1:0] counts, results;
  logic [REFRESH_W-1:0]        refresh;
  logic [DIGITS-1:0]           digit_next;
  logic [BCD_W-1:0]            cur_digit;
  logic                        in_count, in_latch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= signal_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign edges       = sync2 & ~sync3;
  assign in_count    = (state == ST_COUNT);
  assign in_latch    = (state == ST_LATCH);
  // A strobe landing on the LATCH cycle bypasses the shadow so it joins this reload.
  assign period_next = load_period ? period_in : period_shadow;

  // Outside COUNT the counters are held clear; a LATCH-cycle edge opens the next window at one.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    bcd_counter #(.DIGITS(DIGITS)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (!in_count),
      .load_one (in_latch & edges[c]),
      .inc      (in_count & edges[c]),
      .count    (counts[c]),
      .ovf      (cnt_ovf[c])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      period_act    <= '0;
      period_shadow <= '0;
      gate          <= '0;
      results       <= '0;
      overflow      <= '0;
      result_valid  <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (load_period) period_shadow <= period_in;
      case (state)
        ST_IDLE: begin
          gate <= '0;
          if (period_act != '0) state      <= ST_COUNT;
          else                  period_act <= period_shadow;
        end
        ST_COUNT: begin
          gate <= gate + PERIOD_W'(1);
          if (gate == period_act - PERIOD_W'(1)) state <= ST_LATCH;
        end
        ST_LATCH: begin
          results      <= counts;
          overflow     <= cnt_ovf;
          result_valid <= 1'b1;
          gate         <= '0;
          period_act   <= period_next;
          state        <= (period_next != '0) ? ST_COUNT : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dbg_state  = state;
  assign digit_next = (digit_sel << 1) | (digit_sel >> (DIGITS - 1));

  always_comb begin
    cur_digit = '1;
    if (int'(ch_sel) < NUM_CH) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (digit_sel[d]) cur_digit = results[ch_sel][d*BCD_W +: BCD_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh   <= '0;
      digit_sel <= DIGITS'(1);
      segments  <= '0;
    end else begin
      refresh  <= refresh + REFRESH_W'(1);
      if (&refresh) digit_sel <= digit_next;
      segments <= seg_decode(cur_digit);
    end
  end

endmodule
